// File: rtl/credit_tx_pkg.sv
// Shared types and helpers for the credit-based transmitter.
package credit_tx_pkg;

  // FSM encoding exposed on the state port; value 3 is never produced.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_t;

  // Width needed to hold every count from 0 up to and including credits.
  function automatic int cw_for(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/credit_ctr.sv
// Saturating up/down credit counter. Starts full, counts down on each
// word sent, up on each returned credit, and flags a return that would
// push it past its maximum.
module credit_ctr #(
  parameter int CW  = 3,
  parameter int MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero,
  output logic          ovf
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  // Count update written in statement-form ++/-- on a scratch copy so the
  // register itself still updates with a single non-blocking assignment;
  // simultaneous inc and dec cancel, a return at MAX saturates and sets
  // the sticky overflow flag, and dec at zero is ignored.
  always_ff @(posedge clk or posedge rst) begin
    logic [CW-1:0] cnt_n;
    if (rst) begin
      cnt_q <= MAX_C;
      ovf_q <= 1'b0;
    end else begin
      cnt_n = cnt_q;
      if (inc && !dec) begin
        if (cnt_q == MAX_C) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_n++;
        end
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_n--;
      end
      cnt_q <= cnt_n;
    end
  end

  // Status derived straight from the registered count.
  always_comb begin
    cnt  = cnt_q;
    zero = (cnt_q == '0);
    ovf  = ovf_q;
  end

endmodule

// File: rtl/credit_tx.sv
// Transmit side of a credit-based link: one-entry holding register on a
// valid/ready input, words forwarded downstream only while credits remain.
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 4,
  parameter int CW      = cw_for(CREDITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             credit_ret,
  output logic [CW-1:0]    credit_cnt,
  output logic [1:0]       state,
  output logic             err_ovf
);

  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  state_t           state_q, state_d;

  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             send;
  logic             accept;
  logic             next_zero;

  credit_ctr #(
    .CW  (CW),
    .MAX (CREDITS)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (credit_ret),
    .dec  (send),
    .cnt  (cnt),
    .zero (cnt_zero),
    .ovf  (err_ovf)
  );

  // Handshake and next-state: a send needs a held word and a registered
  // credit, so a credit returned this cycle only helps from the next edge.
  // The next count is zero only if nothing comes back and either the count
  // is already zero or the last credit is being spent right now.
  always_comb begin
    send        = hold_full_q && !cnt_zero;
    in_ready    = !hold_full_q || send;
    accept      = in_valid && in_ready;

    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data;
    end else if (send) begin
      hold_full_d = 1'b0;
    end

    out_valid_d = send;
    out_data_d  = send ? hold_data_q : out_data_q;

    if (credit_ret) begin
      next_zero = 1'b0;
    end else if (send) begin
      next_zero = (cnt == CW'(1));
    end else begin
      next_zero = cnt_zero;
    end

    if (!hold_full_d) begin
      state_d = IDLE;
    end else if (next_zero) begin
      state_d = STALL;
    end else begin
      state_d = HOLD;
    end
  end

  // All holding, output and FSM registers; reset drops any held word and
  // any in-flight output pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      state_q     <= IDLE;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      state_q     <= state_d;
    end
  end

  // Output view of the registers; the unused encoding reads back as IDLE.
  always_comb begin
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    credit_cnt = cnt;
    case (state_q)
      HOLD:    state = 2'd1;
      STALL:   state = 2'd2;
      default: state = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_credit_tx.sv
// Directed and randomized checks for the credit-based transmitter.
module tb_credit_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       credit_ret;
  logic [2:0] credit_cnt;
  logic [1:0] state;
  logic       err_ovf;

  int tests_run;
  int tests_failed;

  // Random-test scoreboard state
  logic [7:0] exp_q[$];
  logic [2:0] ret_pipe;
  int         outstanding;
  int         sent_total;
  int         rfail;

  credit_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .state      (state),
    .err_ovf    (err_ovf)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse covering one edge
  task automatic do_reset();
    in_valid   = 1'b0;
    in_data    = 8'h00;
    credit_ret = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset values both while held in reset and right after release
  task automatic test_reset();
    in_valid   = 1'b0;
    in_data    = 8'h00;
    credit_ret = 1'b0;
    rst        = 1'b1;
    tick();
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state, err_ovf} !== {1'b1, 1'b0, 8'h00, 3'd4, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state, err_ovf},
               {1'b1, 1'b0, 8'h00, 3'd4, 2'd0, 1'b0});
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state, err_ovf} !== {1'b1, 1'b0, 8'h00, 3'd4, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_released: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state, err_ovf},
               {1'b1, 1'b0, 8'h00, 3'd4, 2'd0, 1'b0});
    end
  endtask

  // Four words back to back drain all credits, fifth word stalls
  task automatic test_back_to_back();
    logic [14:0] exp;
    logic [7:0]  d;
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    tests_run++;
    exp = {1'b1, 1'b0, 8'h00, 3'd4, 2'd1};
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first_accept: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'hA1 + 8'(k);
      tick();
      d   = 8'hA1 + 8'(k - 1);
      exp = {(k < 4), 1'b1, d, 3'(4 - k), (k < 4) ? 2'd1 : 2'd2};
      tests_run++;
      if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL b2b_send%0d: got %h expected %h", k,
                 {in_ready, out_valid, out_data, credit_cnt, state}, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 8'hA4, 3'd0, 2'd2};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stall: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
  endtask

  // One returned credit releases the stalled word two edges later
  task automatic test_credit_return();
    logic [14:0] exp;
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    exp = {1'b1, 1'b0, 8'hA4, 3'd1, 2'd1};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL ret_unstall: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
    tick();
    exp = {1'b1, 1'b1, 8'hA5, 3'd0, 2'd0};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL ret_send: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
    tick();
    exp = {1'b1, 1'b0, 8'hA5, 3'd0, 2'd0};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL ret_idle_hold_data: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
  endtask

  // Send and credit return in the same cycle leave the count unchanged
  task automatic test_simultaneous_return();
    logic [14:0] exp;
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'h33;
    tick();
    exp = {1'b1, 1'b0, 8'hA5, 3'd2, 2'd1};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL simul_setup: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
    in_valid   = 1'b0;
    credit_ret = 1'b1;
    tick();
    exp = {1'b1, 1'b1, 8'h33, 3'd2, 2'd0};
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL simul_send_ret: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, exp);
    end
    tick();
    tick();
    credit_ret = 1'b0;
    tests_run++;
    if ({credit_cnt, err_ovf} !== {3'd4, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL simul_refill: got %h expected %h", {credit_cnt, err_ovf}, {3'd4, 1'b0});
    end
  endtask

  // Returns at full count: with a send it is legal, without it is sticky error
  task automatic test_overflow();
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    in_valid   = 1'b0;
    credit_ret = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, out_data, credit_cnt, err_ovf} !== {1'b1, 8'h44, 3'd4, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_send_at_max: got %h expected %h",
               {out_valid, out_data, credit_cnt, err_ovf}, {1'b1, 8'h44, 3'd4, 1'b0});
    end
    tick();
    credit_ret = 1'b0;
    tests_run++;
    if ({credit_cnt, err_ovf} !== {3'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_set: got %h expected %h", {credit_cnt, err_ovf}, {3'd4, 1'b1});
    end
    repeat (3) tick();
    tests_run++;
    if ({credit_cnt, err_ovf} !== {3'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_sticky: got %h expected %h", {credit_cnt, err_ovf}, {3'd4, 1'b1});
    end
    do_reset();
    tests_run++;
    if (err_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_cleared: got %b expected 0", err_ovf);
    end
  endtask

  // Reset asserted between edges wipes the held word and the output pulse
  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 8'h5B;
    tick();
    in_data = 8'h5C;
    tick();
    tests_run++;
    if ({out_valid, out_data, credit_cnt, state} !== {1'b1, 8'h5B, 3'd3, 2'd1}) begin
      tests_failed++;
      $display("[TB] FAIL arst_setup: got %h expected %h",
               {out_valid, out_data, credit_cnt, state}, {1'b1, 8'h5B, 3'd3, 2'd1});
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_data, credit_cnt, state} !== {1'b1, 1'b0, 8'h00, 3'd4, 2'd0}) begin
      tests_failed++;
      $display("[TB] FAIL arst_immediate: got %h expected %h",
               {in_ready, out_valid, out_data, credit_cnt, state}, {1'b1, 1'b0, 8'h00, 3'd4, 2'd0});
    end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({out_valid, credit_cnt, state} !== {1'b0, 3'd4, 2'd0}) begin
        tests_failed++;
        $display("[TB] FAIL arst_no_emit%0d: got %h expected %h", k,
                 {out_valid, credit_cnt, state}, {1'b0, 3'd4, 2'd0});
      end
    end
  endtask

  // One cycle of the random run: upstream drives, receiver returns each
  // credit three cycles after the word it saw, scoreboard checks order
  // and that the count equals full minus credits still out.
  task automatic random_cycle(input logic allow_valid);
    logic acc;
    logic ret_now;
    in_valid   = allow_valid && ($urandom_range(0, 99) < 70);
    in_data    = 8'($urandom_range(0, 255));
    credit_ret = ret_pipe[2];
    ret_now    = ret_pipe[2];
    acc        = in_valid && in_ready;
    if (acc) exp_q.push_back(in_data);
    tick();
    if (ret_now) outstanding--;
    if (out_valid === 1'b1) begin
      outstanding++;
      sent_total++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        rfail++;
        $display("[TB] FAIL rnd_order: got word %h expected no word", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          tests_failed++;
          rfail++;
          $display("[TB] FAIL rnd_order: got %h expected %h", out_data, e);
        end
      end
    end
    tests_run++;
    if (credit_cnt !== 3'(4 - outstanding) || credit_cnt > 3'd4) begin
      tests_failed++;
      rfail++;
      $display("[TB] FAIL rnd_count: got %0d expected %0d", credit_cnt, 4 - outstanding);
    end
    tests_run++;
    if (err_ovf !== 1'b0) begin
      tests_failed++;
      rfail++;
      $display("[TB] FAIL rnd_ovf: got %b expected 0", err_ovf);
    end
    ret_pipe = {ret_pipe[1:0], out_valid};
  endtask

  // Long randomized run followed by a drain
  task automatic test_random();
    do_reset();
    exp_q.delete();
    ret_pipe    = 3'b000;
    outstanding = 0;
    sent_total  = 0;
    rfail       = 0;
    for (int i = 0; i < 10000 && rfail < 10; i++) random_cycle(1'b1);
    for (int i = 0; i < 20 && rfail < 10; i++) random_cycle(1'b0);
    in_valid   = 1'b0;
    credit_ret = 1'b0;
    tests_run++;
    if (exp_q.size() != 0 || credit_cnt !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL rnd_drain: got %0d pending count %0d expected 0 pending count 4",
               exp_q.size(), credit_cnt);
    end
    tests_run++;
    if (sent_total < 3000) begin
      tests_failed++;
      $display("[TB] FAIL rnd_progress: got %0d words expected at least 3000", sent_total);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_back_to_back();
    test_credit_return();
    test_simultaneous_return();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
# credit_tx

Transmit side of a credit-based link, the counterpart to the credit-returning receiver that consumes increment/decrement traffic. Accepts words on a valid/ready input into a one-entry holding register. Emits each word downstream only while it holds a credit, decrementing the credit count per word and incrementing it on each returned credit. Serves as the legal, statement-form `++`/`--` counter testcase for the sv flow, alongside the failtests.

## Interface
- `WIDTH`, default 8: data width.
- `CREDITS`, default 4: initial and maximum credit count; legal range 1..15.
- `CW`, default `$clog2(CREDITS+1)`: credit counter width; derived, never overridden.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream word present.
- `in_data` in WIDTH: upstream word.
- `in_ready` out 1: upstream handshake completes on `in_valid && in_ready`.
- `out_valid` out 1: one-cycle pulse; a word is sent downstream (no backpressure).
- `out_data` out WIDTH: sent word, valid only when `out_valid`.
- `credit_ret` in 1: one credit returned by the receiver this cycle.
- `credit_cnt` out CW: current registered credit count.
- `state` out 2: FSM state, encoded IDLE=0, HOLD=1, STALL=2.
- `err_ovf` out 1: sticky; a credit was returned while the count was already `CREDITS`.

## Operation
- Reset values: `credit_cnt`=CREDITS, `state`=IDLE, hold empty, `out_valid`=0, `out_data`=0, `err_ovf`=0, `in_ready`=1.
- `send` = hold full && `credit_cnt`!=0 (registered count only; a same-cycle `credit_ret` does not enable a send).
- `in_ready` = hold empty || `send` (combinational from registers; no path from `in_valid`).
- On `send`: `out_valid`<=1, `out_data`<=hold word; hold is refilled by a same-cycle accept, otherwise emptied. If no `send`, `out_valid`<=0 and `out_data` holds its value.
- Credit update per cycle: `send` only -> count--; `credit_ret` only -> count++; both -> unchanged; neither -> unchanged.
- `credit_ret` at count==CREDITS with no `send`: count stays CREDITS (saturate) and `err_ovf`<=1. Cleared only by `rst`.
- Count never underflows: `send` requires count!=0.
- FSM states, derived for the next cycle from next hold/credit values:
  - IDLE: hold empty.
  - HOLD: hold full, next count != 0.
  - STALL: hold full, next count == 0.
- Transitions:
  - IDLE->HOLD on accept.
  - HOLD->HOLD on send+accept with credits remaining.
  - HOLD->STALL when the last credit is consumed and a word is still held.
  - HOLD->IDLE on send without accept.
  - STALL->HOLD on `credit_ret`.
  - STALL has no other exits. Encoding 3 is unreachable and decodes as IDLE.
- Reset mid-operation drops the held word and any in-flight `out_valid` immediately (asynchronous), and restores full credits.

## Timing
- Latency: a word accepted at edge N is sent with `out_valid` high after edge N+1, given credits are available at N+1.
- Steady-state throughput is 1 word/cycle while credits last. Accept and send may coincide every cycle.
- A returned credit in cycle C is usable for a send at edge C+1, i.e., `out_valid` after C+2 at the earliest from STALL.
- All outputs are registered except `in_ready`.

## Structure
- Package `credit_tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, HOLD, STALL} state_t`.
  - Function for the CW computation.
- Sub-module `credit_ctr`: CW-bit saturating up/down counter with inputs `inc` and `dec` and outputs `cnt`, `zero`, `ovf`.
  - Uses statement-form `cnt++` / `cnt--` inside `always_ff` only.
  - Never embedded in an expression. This is the whole point of the block within the flow.

## Test plan
- Reset, then 4 back-to-back words 0xA1..0xA4 with no returns -> `out_valid` on 4 consecutive cycles, starting 1 cycle after the first accept. `credit_cnt` goes 4,3,2,1,0. Then state=STALL and `in_ready`=0 while a 5th word 0xA5 is held.
- From that STALL state, pulse `credit_ret` once -> 0xA5 is sent 2 cycles later and the count returns to 0. State becomes HOLD then IDLE.
- With count=2 and a word held, assert `credit_ret` in the same cycle as a send -> count stays 2 and `out_valid`=1.
- At count=4, pulse `credit_ret` -> count stays 4 and `err_ovf`=1 persistently. Apply `rst` -> `err_ovf`=0.
- Assert `rst` asynchronously between edges while in HOLD with 0x5C held -> `out_valid`=0, `credit_cnt`=4, state=IDLE before the next edge. 0x5C is never emitted.
- Random `in_valid` and `credit_ret` over 10k cycles, with the receiver model returning each credit 3 cycles after its `out_valid` -> output order equals input order, count stays within 0..4, `err_ovf` stays 0.
